// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package rf_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned ZERO_REG = 31;

    typedef logic [4:0] rf_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STALL = 2'd2
    } arb_state_t;

endpackage

// File: rtl/starve_counter.sv
// Tracks how long an MCU write has been blocked by WB and requests a pipeline
// stall once the wait reaches the starvation limit.
module starve_counter
    import rf_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic mc_valid,
    input  logic mc_ready,
    input  logic wb_live,
    output logic stall_req,
    output logic conflict_err
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t state;
    logic [3:0] wait_cnt;
    logic [3:0] cnt_inc;
    logic       release_req;

    assign cnt_inc     = wait_cnt + 4'd1;
    // Leaving the wait: either the MCU got the port or withdrew its request.
    assign release_req = !mc_valid || mc_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= 4'd0;
            stall_req    <= 1'b0;
            conflict_err <= 1'b0;
        end else begin
            conflict_err <= (state == STALL) && wb_live;
            case (state)
                IDLE: begin
                    if (mc_valid && !mc_ready) begin
                        wait_cnt <= 4'd1;
                        if (LIMIT == 4'd1) begin
                            state     <= STALL;
                            stall_req <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (release_req) begin
                        state    <= IDLE;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= cnt_inc;
                        if (cnt_inc == LIMIT) begin
                            state     <= STALL;
                            stall_req <= 1'b1;
                        end
                    end
                end
                STALL: begin
                    // wait_cnt holds at LIMIT here, so it saturates without wrapping.
                    if (release_req) begin
                        state     <= IDLE;
                        wait_cnt  <= 4'd0;
                        stall_req <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    wait_cnt  <= 4'd0;
                    stall_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/rf_wr_port_arbiter.sv
// Shares the single register-file write port between the WB stage (fixed
// priority) and a multi-cycle unit with a valid/ready handshake.
module rf_wr_port_arbiter #(
    parameter int unsigned DATA_W       = rf_pkg::DATA_W,
    parameter int unsigned ADDR_W       = rf_pkg::ADDR_W,
    parameter int unsigned ZERO_REG     = rf_pkg::ZERO_REG,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_addr,
    input  logic [DATA_W-1:0] mc_data,
    output logic              mc_ready,
    output logic              stall_req,
    output logic              conflict_err,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic wb_live;
    logic mc_live;

    // A WB write to the zero register is discarded, so it leaves the port free.
    assign wb_live  = wb_en && (wb_addr != ZERO_ADDR);
    assign mc_live  = mc_valid && (mc_addr != ZERO_ADDR);
    assign mc_ready = !reset && !wb_live;

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
        end else if (wb_live) begin
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= wb_addr;
            rf_wr_data <= wb_data;
        end else if (mc_live) begin
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= mc_addr;
            rf_wr_data <= mc_data;
        end else begin
            rf_wr_en <= 1'b0;
        end
    end

    starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk          (clk),
        .reset        (reset),
        .mc_valid     (mc_valid),
        .mc_ready     (mc_ready),
        .wb_live      (wb_live),
        .stall_req    (stall_req),
        .conflict_err (conflict_err)
    );

endmodule

// File: tb/tb_rf_wr_port_arbiter.sv
// Directed, table-driven bench for rf_wr_port_arbiter with hand-computed expectations.
module tb_rf_wr_port_arbiter;
    import rf_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        mc_valid;
    logic [4:0]  mc_addr;
    logic [63:0] mc_data;
    logic        mc_ready;
    logic        stall_req;
    logic        conflict_err;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [63:0] rf_wr_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [63:0] wb_data;
        logic        mc_valid;
        logic [4:0]  mc_addr;
        logic [63:0] mc_data;
        logic        e_ready;
        logic        e_en;
        logic [4:0]  e_addr;
        logic [63:0] e_data;
        logic        e_stall;
        logic        e_conf;
        arb_state_t  e_state;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    rf_wr_port_arbiter #(
        .DATA_W       (64),
        .ADDR_W       (5),
        .ZERO_REG     (31),
        .STARVE_LIMIT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .mc_valid     (mc_valid),
        .mc_addr      (mc_addr),
        .mc_data      (mc_data),
        .mc_ready     (mc_ready),
        .stall_req    (stall_req),
        .conflict_err (conflict_err),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_addr   (rf_wr_addr),
        .rf_wr_data   (rf_wr_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [63:0] md,
                       input logic er, input logic ee, input logic [4:0] ea,
                       input logic [63:0] ed, input logic es, input logic ec,
                       input arb_state_t est, input logic [3:0] ecnt);
        vec_t v;
        v.wb_en = we;   v.wb_addr = wa;  v.wb_data = wd;
        v.mc_valid = mv; v.mc_addr = ma; v.mc_data = md;
        v.e_ready = er; v.e_en = ee;     v.e_addr = ea; v.e_data = ed;
        v.e_stall = es; v.e_conf = ec;   v.e_state = est; v.e_cnt = ecnt;
        vq.push_back(v);
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                         input logic mv, input logic [4:0] ma, input logic [63:0] md);
        wb_en = we; wb_addr = wa; wb_data = wd;
        mc_valid = mv; mc_addr = ma; mc_data = md;
    endtask

    task automatic chk_regs(input string tag, input logic ee, input logic [4:0] ea,
                            input logic [63:0] ed, input logic es, input logic ec,
                            input arb_state_t est, input logic [3:0] ecnt);
        chk({tag, ".rf_wr_en"}, 64'(rf_wr_en), 64'(ee));
        chk({tag, ".rf_wr_addr"}, 64'(rf_wr_addr), 64'(ea));
        chk({tag, ".rf_wr_data"}, rf_wr_data, ed);
        chk({tag, ".stall_req"}, 64'(stall_req), 64'(es));
        chk({tag, ".conflict_err"}, 64'(conflict_err), 64'(ec));
        chk({tag, ".state"}, 64'(dut.u_starve.state), 64'(est));
        chk({tag, ".wait_cnt"}, 64'(dut.u_starve.wait_cnt), 64'(ecnt));
    endtask

    initial begin
        // WB only, then WB to XZR (no write, addr/data hold)
        add(1, 5,  64'hAAAA, 0, 0,  64'h0,    0, 1, 5,  64'hAAAA, 0, 0, IDLE, 0);
        add(1, 31, 64'hBBBB, 0, 0,  64'h0,    1, 0, 5,  64'hAAAA, 0, 0, IDLE, 0);
        // MCU only
        add(0, 0,  64'h0,    1, 9,  64'h1234, 1, 1, 9,  64'h1234, 0, 0, IDLE, 0);
        // Same-address contention, then XZR bypass lets MCU through
        add(1, 3,  64'h3333, 1, 3,  64'h4444, 0, 1, 3,  64'h3333, 0, 0, WAIT, 1);
        add(1, 31, 64'h5555, 1, 3,  64'h4444, 1, 1, 3,  64'h4444, 0, 0, IDLE, 0);
        // Starvation: six blocked cycles
        add(1, 10, 64'hA0,   1, 12, 64'hCCCC, 0, 1, 10, 64'hA0,   0, 0, WAIT, 1);
        add(1, 11, 64'hA1,   1, 12, 64'hCCCC, 0, 1, 11, 64'hA1,   0, 0, WAIT, 2);
        add(1, 12, 64'hA2,   1, 12, 64'hCCCC, 0, 1, 12, 64'hA2,   0, 0, WAIT, 3);
        add(1, 13, 64'hA3,   1, 12, 64'hCCCC, 0, 1, 13, 64'hA3,   1, 0, STALL, 4);
        add(1, 14, 64'hA4,   1, 12, 64'hCCCC, 0, 1, 14, 64'hA4,   1, 1, STALL, 4);
        add(1, 15, 64'hA5,   1, 12, 64'hCCCC, 0, 1, 15, 64'hA5,   1, 1, STALL, 4);
        add(0, 0,  64'h0,    1, 12, 64'hCCCC, 1, 1, 12, 64'hCCCC, 0, 0, IDLE, 0);
        // Back into STALL, then a single WB violation
        add(1, 20, 64'hB0,   1, 13, 64'hDDDD, 0, 1, 20, 64'hB0,   0, 0, WAIT, 1);
        add(1, 21, 64'hB1,   1, 13, 64'hDDDD, 0, 1, 21, 64'hB1,   0, 0, WAIT, 2);
        add(1, 22, 64'hB2,   1, 13, 64'hDDDD, 0, 1, 22, 64'hB2,   0, 0, WAIT, 3);
        add(1, 23, 64'hB3,   1, 13, 64'hDDDD, 0, 1, 23, 64'hB3,   1, 0, STALL, 4);
        add(1, 7,  64'h7777, 1, 13, 64'hDDDD, 0, 1, 7,  64'h7777, 1, 1, STALL, 4);
        add(0, 0,  64'h0,    1, 13, 64'hDDDD, 1, 1, 13, 64'hDDDD, 0, 0, IDLE, 0);
        // Drop mc_valid in WAIT
        add(1, 4,  64'h4040, 1, 14, 64'hEEEE, 0, 1, 4,  64'h4040, 0, 0, WAIT, 1);
        add(0, 0,  64'h0,    0, 0,  64'h0,    1, 0, 4,  64'h4040, 0, 0, IDLE, 0);
        // MCU write to XZR completes but writes nothing
        add(0, 0,  64'h0,    1, 31, 64'hFFFF, 1, 0, 4,  64'h4040, 0, 0, IDLE, 0);

        reset = 1'b1;
        drive(0, 0, 64'h0, 0, 0, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.mc_ready", 64'(mc_ready), 64'h0);
        chk_regs("rst", 0, 0, 64'h0, 0, 0, IDLE, 0);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].wb_en, vq[i].wb_addr, vq[i].wb_data,
                  vq[i].mc_valid, vq[i].mc_addr, vq[i].mc_data);
            @(negedge clk);
            chk($sformatf("v%0d.mc_ready", i), 64'(mc_ready), 64'(vq[i].e_ready));
            @(posedge clk);
            #1;
            chk_regs($sformatf("v%0d", i), vq[i].e_en, vq[i].e_addr, vq[i].e_data,
                     vq[i].e_stall, vq[i].e_conf, vq[i].e_state, vq[i].e_cnt);
        end

        // Reset while stalled abandons the MCU request
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'(8 + i), 64'(256 + i), 1, 15, 64'hF0F0);
            @(posedge clk);
            #1;
        end
        chk_regs("pre_rst", 1, 11, 64'h103, 1, 0, STALL, 4);
        reset = 1'b1;
        drive(0, 0, 64'h0, 1, 15, 64'hF0F0);
        @(negedge clk);
        chk("mid_rst.mc_ready", 64'(mc_ready), 64'h0);
        @(posedge clk);
        #1;
        chk_regs("mid_rst", 0, 0, 64'h0, 0, 0, IDLE, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst.mc_ready", 64'(mc_ready), 64'h1);
        @(posedge clk);
        #1;
        chk_regs("post_rst", 1, 15, 64'hF0F0, 0, 0, IDLE, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
